// File: rtl/mfcc_pkg.sv
// Purpose  : shared constants and FSM encoding for the MFCC delta stage.
// Latency  : n/a (declarations only).
// Backpres.: n/a (declarations only).
package mfcc_pkg;
   localparam int NCOEF    = 13;      // coefficients per frame
   localparam int DWIDTH   = 26;      // signed coefficient width, in and out
   localparam int SLOTS_AW = 3;       // 8 history slots, 5 in use
   localparam int IDX_AW   = 4;       // coefficient address bits per slot
   localparam int AW       = SLOTS_AW + IDX_AW;
   localparam int RECIP    = 6554;    // unsigned Q16 approximation of 1/10
   localparam int NWIN     = 2;       // regression window half-width
   localparam int NFRAMES  = 2*NWIN + 1;
   localparam int SWIDTH   = 29;      // regression numerator width
   localparam int RWIDTH   = 15;      // RECIP as a signed operand
   localparam int PWIDTH   = SWIDTH + RWIDTH;
   localparam int SHIFT    = 16;      // Q16 back to integer
   localparam int RND      = 1 << (SHIFT - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      STAT  = 2'd1,
      DELTA = 2'd2,
      DONE  = 2'd3
   } state_t;
endpackage

// File: rtl/mfcc_hist_ram.sv
// Purpose  : simple dual-port frame history RAM, address {slot, coef index}.
// Latency  : write lands at the clock edge; read data registered, 1 cycle.
// Backpres.: none; one write and one read may occur every cycle.
// Ports    : clk; wr_en/wr_addr/wr_dat write port; rd_addr in, rd_dat out.
module mfcc_hist_ram
   import mfcc_pkg::*;
(
   input  logic              clk,
   input  logic              wr_en,
   input  logic [AW-1:0]     wr_addr,
   input  logic [DWIDTH-1:0] wr_dat,
   input  logic [AW-1:0]     rd_addr,
   output logic [DWIDTH-1:0] rd_dat
);
   logic [DWIDTH-1:0] mem [2**AW];

   // Contents are not reset; the write and read slots never coincide.
   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_addr] <= wr_dat;
      rd_dat <= mem[rd_addr];
   end
endmodule

// File: rtl/mfcc_delta.sv
// Purpose  : keeps 5 frames of MFCC statics, emits statics then N=2 regression deltas.
// Latency  : static k at C+3+k after commit cycle C; deltas every 4 cycles, last by C+69.
// Backpres.: none; a commit while busy is stored, flagged on overrun, and not computed.
// Ports    : clk, sclr (sync, active high); x_i/index_in/dv_in frame input;
//            x_o/out_index/dv_out output stream; busy, overrun status.
module mfcc_delta
   import mfcc_pkg::*;
(
   input  logic              clk,
   input  logic              sclr,
   input  logic [DWIDTH-1:0] x_i,
   input  logic [4:0]        index_in,
   input  logic              dv_in,
   output logic [DWIDTH-1:0] x_o,
   output logic [4:0]        out_index,
   output logic              dv_out,
   output logic              busy,
   output logic              overrun
);
   localparam logic signed [RWIDTH-1:0] RECIP_S = RWIDTH'(RECIP);

   state_t                   state;
   logic                     dv_in_d;
   logic [SLOTS_AW-1:0]      wr_slot;
   logic [SLOTS_AW-1:0]      t_slot;       // centre frame, latched at launch
   logic [2:0]               fcnt;
   logic [2:0]               fcnt_nxt;
   logic                     commit;
   logic                     launch;
   logic                     wr_en;
   logic [4:0]               k;
   logic [1:0]               ph;           // delta read phase: t+2, t-2, t+1, t-1
   logic                     iss_delta;
   logic [SLOTS_AW-1:0]      rd_slot;
   logic [AW-1:0]            rd_addr;
   logic [DWIDTH-1:0]        rd_dat;
   // read-return stage, aligned with rd_dat
   logic                     s1_stat;
   logic                     s1_delta;
   logic [4:0]               s1_k;
   logic [1:0]               s1_ph;
   logic signed [SWIDTH-1:0] rd_ext;
   logic signed [SWIDTH-1:0] rd_x2;
   logic signed [SWIDTH-1:0] acc;
   logic signed [SWIDTH-1:0] s_fin;
   // multiply stage
   logic signed [PWIDTH-1:0] prod;
   logic                     prod_vld;
   logic [4:0]               prod_k;

   assign commit    = dv_in_d & ~dv_in;
   assign fcnt_nxt  = (fcnt == 3'(NFRAMES)) ? fcnt : fcnt + 3'd1;
   assign launch    = commit & ~busy & (fcnt_nxt == 3'(NFRAMES));
   assign wr_en     = dv_in & (index_in < 5'(NCOEF));
   assign iss_delta = (state == DELTA) && (k < 5'(NCOEF));

   always_comb begin
      rd_slot = t_slot;
      if (state == DELTA) begin
         case (ph)
            2'd0:    rd_slot = t_slot + SLOTS_AW'(2);
            2'd1:    rd_slot = t_slot - SLOTS_AW'(2);
            2'd2:    rd_slot = t_slot + SLOTS_AW'(1);
            default: rd_slot = t_slot - SLOTS_AW'(1);
         endcase
      end
   end
   assign rd_addr = {rd_slot, k[IDX_AW-1:0]};

   mfcc_hist_ram u_ram (
      .clk     (clk),
      .wr_en   (wr_en),
      .wr_addr ({wr_slot, index_in[IDX_AW-1:0]}),
      .wr_dat  (x_i),
      .rd_addr (rd_addr),
      .rd_dat  (rd_dat)
   );

   assign rd_ext = {{(SWIDTH-DWIDTH){rd_dat[DWIDTH-1]}}, rd_dat};
   assign rd_x2  = rd_ext <<< 1;
   assign s_fin  = acc - rd_ext;             // phase 3 closes the numerator

   always_ff @(posedge clk) begin
      if (sclr) begin
         state     <= IDLE;
         dv_in_d   <= 1'b0;
         wr_slot   <= '0;
         t_slot    <= '0;
         fcnt      <= '0;
         k         <= '0;
         ph        <= '0;
         busy      <= 1'b0;
         overrun   <= 1'b0;
         s1_stat   <= 1'b0;
         s1_delta  <= 1'b0;
         s1_k      <= '0;
         s1_ph     <= '0;
         acc       <= '0;
         prod      <= '0;
         prod_vld  <= 1'b0;
         prod_k    <= '0;
         x_o       <= '0;
         out_index <= '0;
         dv_out    <= 1'b0;
      end else begin
         dv_in_d <= dv_in;
         overrun <= commit & busy;
         dv_out  <= 1'b0;
         if (commit) begin
            wr_slot <= wr_slot + SLOTS_AW'(1);
            fcnt    <= fcnt_nxt;
         end

         s1_stat  <= (state == STAT);
         s1_delta <= iss_delta;
         s1_k     <= k;
         s1_ph    <= ph;

         case (state)
            IDLE: if (launch) begin
               state  <= STAT;
               busy   <= 1'b1;
               // committed slot is t+2, so t is two behind the pre-increment pointer
               t_slot <= wr_slot - SLOTS_AW'(2);
               k      <= '0;
               ph     <= '0;
            end
            STAT: begin
               if (k == 5'(NCOEF-1)) begin
                  k     <= '0;
                  state <= DELTA;
               end else begin
                  k <= k + 5'd1;
               end
            end
            DELTA: begin
               if (iss_delta) begin
                  ph <= ph + 2'd1;
                  if (ph == 2'd3) k <= k + 5'd1;
               end
               if (prod_vld && prod_k == 5'(NCOEF-1)) state <= DONE;
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase

         if (s1_stat) begin
            x_o       <= rd_dat;
            out_index <= s1_k;
            dv_out    <= 1'b1;
         end

         if (s1_delta) begin
            case (s1_ph)
               2'd0:    acc <= rd_x2;
               2'd1:    acc <= acc - rd_x2;
               2'd2:    acc <= acc + rd_ext;
               default: acc <= acc;
            endcase
         end
         prod_vld <= s1_delta && (s1_ph == 2'd3);
         if (s1_delta && s1_ph == 2'd3) begin
            prod   <= s_fin * RECIP_S;
            prod_k <= s1_k;
         end

         // round half up, then drop to DWIDTH (range cannot overflow)
         if (prod_vld) begin
            x_o       <= DWIDTH'((prod + PWIDTH'(RND)) >>> SHIFT);
            out_index <= 5'(NCOEF) + prod_k;
            dv_out    <= 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_mfcc_delta.sv
module tb_mfcc_delta;
   localparam int NC = 13;
   localparam longint MAXV = (longint'(1) << 25) - 1;
   localparam longint MINV = -(longint'(1) << 25);

   logic        clk = 1'b0;
   logic        sclr;
   logic [25:0] x_i;
   logic [4:0]  index_in;
   logic        dv_in;
   logic [25:0] x_o;
   logic [4:0]  out_index;
   logic        dv_out;
   logic        busy;
   logic        overrun;

   mfcc_delta dut (
      .clk       (clk),
      .sclr      (sclr),
      .x_i       (x_i),
      .index_in  (index_in),
      .dv_in     (dv_in),
      .x_o       (x_o),
      .out_index (out_index),
      .dv_out    (dv_out),
      .busy      (busy),
      .overrun   (overrun)
   );

   always #5 clk = ~clk;

   typedef longint frame_t [NC];
   typedef struct {longint val; int idx;} exp_t;

   exp_t   exp_q[$];
   frame_t hist[$];
   exp_t   mon_e;
   int     model_cnt = 0;
   int     n_vec = 0;
   int     n_err = 0;
   int     n_strobe = 0;
   int     n_ovr = 0;

   task automatic chk(input string tag, input longint obs, input longint exp);
      n_vec++;
      if (obs != exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
      end
   endtask

   function automatic longint delta_of(input longint p2, input longint m2,
                                       input longint p1, input longint m1);
      longint s, p, d;
      s = 2*(p2 - m2) + (p1 - m1);
      p = s * 6554;
      d = (p + 32768) >>> 16;
      d = d & ((longint'(1) << 26) - 1);
      if (d >= (longint'(1) << 25)) d = d - (longint'(1) << 26);
      return d;
   endfunction

   // Scoreboard consumer: every strobe must match the oldest expectation.
   always @(negedge clk) begin
      if (overrun) n_ovr++;
      if (dv_out) begin
         n_strobe++;
         if (exp_q.size() == 0) begin
            chk("spurious_dv", dv_out, 0);
         end else begin
            mon_e = exp_q.pop_front();
            chk($sformatf("x_o[%0d]", mon_e.idx), $signed(x_o), mon_e.val);
            chk($sformatf("out_index[%0d]", mon_e.idx), out_index, mon_e.idx);
         end
      end
   end

   task automatic drive(input logic v, input int idx, input longint val);
      @(posedge clk); #1;
      dv_in    = v;
      index_in = 5'(idx);
      x_i      = val[25:0];
   endtask

   // Drives the commit cycle and updates the reference window.
   task automatic commit_frame(input frame_t f, input bit exp_ovr);
      drive(1'b0, 0, 0);
      hist.push_back(f);
      if (hist.size() > 5) hist.delete(0);
      if (model_cnt < 5) model_cnt++;
      if (model_cnt == 5 && !exp_ovr) begin
         for (int k = 0; k < NC; k++)
            exp_q.push_back('{val: hist[2][k], idx: k});
         for (int k = 0; k < NC; k++)
            exp_q.push_back('{val: delta_of(hist[4][k], hist[0][k], hist[3][k], hist[1][k]),
                              idx: NC + k});
      end
   endtask

   task automatic send_frame(input frame_t f, input bit junk, input bit exp_ovr);
      if (junk) drive(1'b1, 0, -777);
      for (int k = 0; k < NC; k++) begin
         if (junk) drive(1'b1, 16 + k, 12345 + k);   // aliases k in the low index bits
         drive(1'b1, k, f[k]);
      end
      if (junk) begin
         drive(1'b1, 31, MAXV);
         drive(1'b1, 13, MINV);
         drive(1'b1, 0, f[0]);
      end
      commit_frame(f, exp_ovr);
   endtask

   task automatic wait_idle(input string tag);
      int n = 0;
      while ((exp_q.size() != 0 || busy) && n < 400) begin
         @(negedge clk);
         n++;
      end
      chk({tag, "_drained"}, exp_q.size(), 0);
      chk({tag, "_busy"}, busy, 0);
      repeat (40) @(posedge clk);
   endtask

   function automatic frame_t fill(input longint base, input longint step);
      frame_t f;
      for (int k = 0; k < NC; k++) f[k] = base + step * k;
      return f;
   endfunction

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      frame_t f;
      int     n;
      int     s0;
      int     o0;

      sclr = 1'b1; dv_in = 1'b0; index_in = '0; x_i = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_x_o", x_o, 0);
      chk("rst_out_index", out_index, 0);
      chk("rst_dv_out", dv_out, 0);
      chk("rst_busy", busy, 0);
      chk("rst_overrun", overrun, 0);
      @(posedge clk); #1 sclr = 1'b0;

      // constant frames: only the 5th produces output
      for (int t = 0; t < 5; t++) begin
         send_frame(fill(500, 0), 1'b0, 1'b0);
         wait_idle("const");
         if (t == 3) chk("const_silent4", n_strobe, 0);
      end
      chk("const_strobes", n_strobe, 26);

      // ramp c_t(k) = 100t + k
      for (int t = 0; t < 5; t++) begin
         send_frame(fill(100 * t, 1), 1'b0, 1'b0);
         wait_idle("ramp");
      end

      // extremes and the negated pattern
      for (int t = 0; t < 10; t++) begin
         case (t % 5)
            0: f = fill((t < 5) ? MINV : MAXV, 0);
            1: f = fill(0, 0);
            2: f = fill(7, -3);
            3: f = fill(0, 0);
            default: f = fill((t < 5) ? MAXV : MINV, 0);
         endcase
         send_frame(f, 1'b0, 1'b0);
         wait_idle("extreme");
      end

      // overrun: 6th frame commits ~20 cycles after the 5th
      o0 = n_ovr;
      chk("no_early_overrun", o0, 0);
      send_frame(fill(-4000, 37), 1'b0, 1'b0);
      repeat (6) @(posedge clk);
      send_frame(fill(9000, -211), 1'b0, 1'b1);
      wait_idle("ovr");
      chk("overrun_pulses", n_ovr - o0, 1);
      send_frame(fill(-123, 999), 1'b0, 1'b0);
      wait_idle("after_ovr");

      // out-of-range indices and rewrites, then two frames to centre it
      for (int k = 0; k < NC; k++)
         f[k] = longint'($urandom_range(0, 1 << 20)) - (longint'(1) << 19);
      send_frame(f, 1'b1, 1'b0);
      wait_idle("junk");
      send_frame(fill(11, 13), 1'b0, 1'b0);
      wait_idle("junk1");
      send_frame(fill(-17, 5), 1'b0, 1'b0);
      wait_idle("junk2");

      // reset during the delta phase
      send_frame(fill(321, -9), 1'b0, 1'b0);
      n = 0;
      while (!(dv_out && out_index >= 5'(NC)) && n < 300) begin
         @(negedge clk);
         n++;
      end
      chk("reach_delta_dv", dv_out, 1);
      @(posedge clk); #1 sclr = 1'b1;
      @(posedge clk); #1 sclr = 1'b0;
      exp_q.delete();
      hist.delete();
      model_cnt = 0;
      s0 = n_strobe;
      @(negedge clk);
      chk("midrst_busy", busy, 0);
      chk("midrst_dv_out", dv_out, 0);
      repeat (100) @(posedge clk);
      chk("midrst_no_dv", n_strobe - s0, 0);
      for (int t = 0; t < 4; t++) begin
         send_frame(fill(50 * t - 60, 3), 1'b0, 1'b0);
         wait_idle("postrst");
      end
      chk("postrst_silent4", n_strobe - s0, 0);
      send_frame(fill(777, -7), 1'b0, 1'b0);
      wait_idle("postrst5");
      chk("postrst_strobes", n_strobe - s0, 26);

      chk("queue_empty", exp_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/mfcc_delta.md
Name: mfcc_delta

Overview:
- Streaming stage directly downstream of the MFCC extractor.
- Consumes one frame of static cepstra per 10 ms: coefficients x_i, tagged by index_in and qualified by dv_in.
- Keeps a short history of frames and emits, per frame, the static coefficients followed by first-order regression deltas (window N=2).
- The resulting 2*NCOEF-dimensional vector feeds the DNN input buffer.

Parameters:
- NCOEF, 13, coefficients per frame (valid index 0..NCOEF-1).
- DWIDTH, 26, signed coefficient width, input and output.
- SLOTS_AW, 3, log2 of history slots (8 slots, only 5 used).
- IDX_AW, 4, coefficient address bits per slot (NCOEF <= 2^IDX_AW).
- RECIP, 6554, unsigned Q16 approximation of 1/10.

Ports:
- clk  in  1  system clock
- sclr  in  1  synchronous active-high reset
- x_i  in  DWIDTH  signed static MFCC coefficient
- index_in  in  5  coefficient index of x_i
- dv_in  in  1  x_i/index_in valid
- x_o  out  DWIDTH  signed static or delta value
- out_index  out  5  0..NCOEF-1 static, NCOEF..2*NCOEF-1 delta
- dv_out  out  1  one-cycle strobe per output value
- busy  out  1  computation in progress
- overrun  out  1  one-cycle pulse when a frame commit arrives while busy

Behaviour:
- Reset: one clock; the reset is synchronous and active-high. sclr=1 at a clock edge clears:
  - x_o=0, out_index=0, dv_out=0, busy=0, overrun=0
  - write pointer=0, frame count=0, FSM=IDLE
  - RAM contents are don't-care. sclr mid-computation aborts with no further dv_out.
- Storage: simple dual-port RAM, 2^(SLOTS_AW+IDX_AW) x DWIDTH.
  - Write address {wr_slot, index_in}; read port has 1-cycle latency.
  - A write occurs every cycle dv_in=1 and index_in<NCOEF. Indices >= NCOEF are ignored.
- Commit: detected in the first cycle with dv_in=0 whose previous cycle had dv_in=1 (cycle C). At C:
  - wr_slot increments mod 8.
  - frame count saturates at 5.
  - The committed slot becomes t+2. The centre frame t is wr_slot-3 (mod 8), with neighbours t±1 and t±2.
  - Writes for the next frame may proceed during computation. They target a slot that is never among the 5 being read.
- FSM states: IDLE, STAT, DELTA, DONE.
  - IDLE -> STAT at commit when frame count (after increment) is 5. Otherwise stay in IDLE; the first 4 frames produce no output.
  - busy=1 from C+1 until the cycle after the last dv_out.
  - Commit while busy: overrun pulses for 1 cycle, the frame is stored and counted, and no computation is launched for it.
- STAT: reads c_t(k) for k=0..NCOEF-1 on consecutive cycles.
  - x_o=c_t(k), out_index=k, dv_out=1 at cycle C+3+k (one per cycle, contiguous).
- DELTA: for each k, four reads c_{t+2}, c_{t-2}, c_{t+1}, c_{t-1}.
  - s = 2*(c_{t+2}-c_{t-2}) + (c_{t+1}-c_{t-1}), 29-bit signed.
  - p = s*RECIP, 44-bit signed.
  - d = (p + 32768) >>> 16, arithmetic shift (round half up). Truncate to DWIDTH; range analysis guarantees no overflow, so no saturation logic.
  - x_o=d, out_index=NCOEF+k, dv_out=1. Deltas are emitted in ascending k, spaced at most 6 cycles apart.
  - Last delta no later than C+8*NCOEF+8.
- DONE -> IDLE the following cycle, busy=0.
- Multiplication: one registered 29x15 signed multiply, shared across k.
- Frames must arrive at least 8*NCOEF+10 cycles apart for full output; faster arrival triggers overrun as above.

Decomposition:
- Shared package/header `mfcc_pkg`: NCOEF, DWIDTH, RECIP, FSM state encodings, delta window N=2.
- One natural sub-module: `mfcc_hist_ram`, the simple dual-port history RAM (write port + registered read port), instantiated once.

Test Plan:
- Reset mid-DELTA: assert sclr during the deltas -> no further dv_out, busy=0. The next 4 frames give no output; the 5th gives output.
- Constant frames, all coefficients=500, 5 frames -> 13 statics =500 at indices 0..12, 13 deltas =0 at indices 13..25. Exactly 26 dv_out strobes.
- Ramp c_t(k)=100*t+k for t=0..4 -> statics 200+k. Every delta =100 (s=1000, p=6554000, rounded 100).
- Extremes: c_{t+2}=2^25-1, c_{t-2}=-2^25, c_{t±1}=0 -> delta = (((2^27-2)*6554+32768)>>>16) = 13422592, no wrap. Negated pattern gives the symmetric negative value.
- Overrun: commit a 6th frame 20 cycles after the 5th -> overrun pulses once, the current output sequence completes unaltered. The 7th frame (spaced correctly) computes with the 6th frame included in its window.
- Index 13..31 and gapped dv_in: writes at index_in>=NCOEF do not corrupt stored data. Statics match the last written values for indices 0..12.
